// File: rtl/mult_seq_if.sv
// mult_seq_if: bundles the request side (start, matrices, result, status) and
// the mult_M side (lin/col out, n_in/ovf_in back) of the sequential 5x5 int8
// matrix multiplier.
//   master: requester/mult_M environment (drives start, mat_a, mat_b, n_in, ovf_in)
//   slave : mult_seq itself (drives lin, col, result, ovf, busy, done)
interface mult_seq_if;
  logic         start;
  logic [199:0] mat_a;
  logic [199:0] mat_b;
  logic [79:0]  lin;
  logic [79:0]  col;
  logic [31:0]  n_in;
  logic         ovf_in;
  logic [199:0] result;
  logic         ovf;
  logic         busy;
  logic         done;

  modport master (output start, mat_a, mat_b, n_in, ovf_in,
                  input  lin, col, result, ovf, busy, done);
  modport slave  (input  start, mat_a, mat_b, n_in, ovf_in,
                  output lin, col, result, ovf, busy, done);
endinterface

// File: rtl/mult_seq.sv
// mult_seq: computes C = A*B for 5x5 signed int8 matrices by walking nine 2x2
// output tiles through an external 2x2 tile multiplier (mult_M). The 5x5
// matrix is treated as 6x6 with a zero row/column 5, so edge tiles use
// all-zero halves and their padded results are discarded.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - mult_seq_if.slave: start/mat_a/mat_b in, result/ovf/busy/done out,
//          lin/col to mult_M, n_in/ovf_in from mult_M
module mult_seq (
  input  logic     clk,
  input  logic     rst,
  mult_seq_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_CAPTURE, S_DONE} state_t;

  state_t            r_state;
  logic [3:0]        r_k;
  logic [199:0]      r_a, r_b;
  logic [79:0]       r_lin, r_col;
  logic [24:0][7:0]  r_res;     // element 24 is C[0][0] (MSB-first packing)
  logic              r_ovf, r_busy, r_done;

  // Row i of a packed matrix; index 5 is the zero padding row.
  function automatic logic [39:0] row_of(input logic [199:0] m, input logic [3:0] i);
    row_of = '0;
    for (int ii = 0; ii < 5; ii++)
      if (i == 4'(ii)) row_of = m[199-40*ii -: 40];
  endfunction

  // Column j of a packed matrix, element i at [39-8i -: 8]; index 5 is zero.
  function automatic logic [39:0] col_of(input logic [199:0] m, input logic [3:0] j);
    col_of = '0;
    for (int jj = 0; jj < 5; jj++)
      if (j == 4'(jj))
        for (int e = 0; e < 5; e++)
          col_of[39-8*e -: 8] = m[199-8*(5*e+jj) -: 8];
  endfunction

  // Current tile origin (used when capturing) and next tile origin (used when
  // loading lin/col on the edge into ISSUE).
  logic [3:0] w_rp, w_cp, w_r, w_c;
  logic [3:0] w_k_nxt, w_rp_nxt, w_cp_nxt, w_r_nxt, w_c_nxt;
  logic [79:0] w_lin_nxt, w_col_nxt;
  logic [3:0]       w_wen;
  logic [3:0][4:0]  w_pos;

  always_comb begin
    w_rp     = r_k / 4'd3;
    w_cp     = r_k % 4'd3;
    w_r      = w_rp << 1;
    w_c      = w_cp << 1;
    w_k_nxt  = (r_state == S_CAPTURE) ? 4'(r_k + 4'd1) : 4'd0;
    w_rp_nxt = w_k_nxt / 4'd3;
    w_cp_nxt = w_k_nxt % 4'd3;
    w_r_nxt  = w_rp_nxt << 1;
    w_c_nxt  = w_cp_nxt << 1;
    w_lin_nxt = {row_of(r_a, w_r_nxt), row_of(r_a, 4'(w_r_nxt + 4'd1))};
    w_col_nxt = {col_of(r_b, w_c_nxt), col_of(r_b, 4'(w_c_nxt + 4'd1))};
    // n_in byte q covers C[r + q/2][c + q%2]; only in-range bytes are kept.
    w_wen = '0;
    w_pos = '0;
    for (int q = 0; q < 4; q++) begin
      w_wen[q] = (4'(w_r + 4'(q/2)) <= 4'd4) && (4'(w_c + 4'(q%2)) <= 4'd4);
      w_pos[q] = 5'(5*(w_r + 4'(q/2)) + (w_c + 4'(q%2)));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_lin   <= '0;
      r_col   <= '0;
      r_res   <= '0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_a     <= bus.mat_a;
          r_b     <= bus.mat_b;
          r_res   <= '0;
          r_ovf   <= 1'b0;
          r_k     <= '0;
          r_busy  <= 1'b1;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_lin   <= w_lin_nxt;
          r_col   <= w_col_nxt;
          r_state <= S_ISSUE;
        end
        S_ISSUE: r_state <= S_CAPTURE;
        S_CAPTURE: begin
          for (int p = 0; p < 25; p++)
            for (int q = 0; q < 4; q++)
              if (w_wen[q] && w_pos[q] == 5'(p))
                r_res[24-p] <= bus.n_in[31-8*q -: 8];
          r_ovf <= r_ovf | bus.ovf_in;
          if (r_k == 4'd8) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_k     <= 4'(r_k + 4'd1);
            r_lin   <= w_lin_nxt;
            r_col   <= w_col_nxt;
            r_state <= S_ISSUE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.lin    = r_lin;
  assign bus.col    = r_col;
  assign bus.result = r_res;
  assign bus.ovf    = r_ovf;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; rst=0 forces the reset state immediately, independent of clk.
REQ-003 start  input  1  request one 5x5 int8 matrix product; sampled only in IDLE.
REQ-004 mat_a  input  200  matrix A; A[i][j] at bits [199-8*(5i+j) -: 8], signed two's complement, rows MSB-first.
REQ-005 mat_b  input  200  matrix B; same packing as mat_a.
REQ-006 lin  output  80  to mult_M: [79:40] = A row r, [39:0] = A row r+1; row element j at [39-8j -: 8] within its 40-bit half.
REQ-007 col  output  80  to mult_M: [79:40] = B column c, [39:0] = B column c+1; column element i at [39-8i -: 8] within its 40-bit half.
REQ-008 n_in  input  32  from mult_M n_out: [31:24]=C[r][c], [23:16]=C[r][c+1], [15:8]=C[r+1][c], [7:0]=C[r+1][c+1].
REQ-009 ovf_in  input  1  from mult_M ovf.
REQ-010 result  output  200  product C, same packing as mat_a.
REQ-011 ovf  output  1  sticky overflow for the current or last product.
REQ-012 busy  output  1  high in LOAD, ISSUE and CAPTURE.
REQ-013 done  output  1  one-cycle pulse; result and ovf are final while it is high.

Function
REQ-014 States: IDLE, LOAD, ISSUE, CAPTURE, DONE.
REQ-015 IDLE with start=1: latch mat_a/mat_b into internal registers, clear result and ovf to 0, clear tile index k to 0, go to LOAD; IDLE with start=0: stay.
REQ-016 LOAD to ISSUE unconditionally.
REQ-017 Tile k (0..8): rp=k/3, cp=k%3, r=2rp, c=2cp; row-major order.
REQ-018 lin and col shall be registered and loaded for tile k on the edge entering ISSUE for that tile, from latched matrices only.
REQ-019 Index 5 (padding) shall drive an all-zero 40-bit half on lin or col.
REQ-020 ISSUE to CAPTURE unconditionally; lin/col held constant through ISSUE and CAPTURE.
REQ-021 On the edge leaving CAPTURE: write each n_in byte into result only where both its row and column index are <=4, discard padded bytes, and set ovf |= ovf_in.
REQ-022 CAPTURE with k<8: k+1, go to ISSUE; CAPTURE with k=8: go to DONE.
REQ-023 DONE: done=1 for exactly that cycle, then go to IDLE unconditionally.
REQ-024 Timing: start sampled at edge 0; LOAD entered at edge 1; tile k ISSUE at edge 2k+2, CAPTURE at 2k+3; DONE at edge 20.
REQ-025 start in LOAD, ISSUE, CAPTURE or DONE shall be ignored and not queued.
REQ-026 start held high shall give back-to-back products, each taking 21 cycles including the IDLE cycle.
REQ-027 result and ovf shall hold after DONE until the next accepted start.
REQ-028 ovf_in outside CAPTURE shall be ignored.
REQ-029 mat_a/mat_b changes after acceptance shall not affect the product in progress.

Reset
REQ-030 rst=0: state=IDLE, k=0, lin=0, col=0, result=0, ovf=0, busy=0, done=0, latched matrices=0, all asynchronously.
REQ-031 Reset mid-operation shall abandon the product with no partial done; the first start after release shall behave per REQ-024.

Verification
REQ-032 Identity test, mult_M connected: A=I, B[i][j]=5i+j -> done at edge 20, result=B, ovf=0, busy high at edges 1..19.
REQ-033 Constant test, mult_M connected: A all 0x01, B all 0x02 -> all 25 result bytes 0x0A, ovf=0.
REQ-034 Mapping/padding test, stub drives n_in=0x11223344, ovf_in=0 -> C[even][even]=0x11, C[even][odd]=0x22, C[odd][even]=0x33, C[odd][odd]=0x44; lin[39:0]=0 during tiles 6..8; col[39:0]=0 during tiles 2,5,8.
REQ-035 Overflow test, mult_M connected: A all 0x7F, B all 0x01 -> ovf=1 at done; ovf returns to 0 on the edge accepting the next start.
REQ-036 Start pulses at edges 5 and 20 -> exactly one done at edge 20; no restart.
REQ-037 rst=0 at edge 10 mid-product -> all outputs 0 immediately; after release, start -> done 20 edges later with correct result.
